mem_port_arbiter: RTL and testbench

//  Single-port memory arbiter/sequencer in front of the pico SoC word memory. Shares one

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter/sequencer for a single synchronous-read word memory port.
// Define MEM_ARB_RR_EN for round-robin priority; default is fixed mc > dt > if.
module mem_port_arbiter #(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned MPU_START_ADDR = 768,
  parameter int unsigned MPU_ITEM_NUM   = 16,
  parameter int unsigned MPU_ITEM_LEN   = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_valid,
  input  logic [21:0] if_addr,
  output logic        if_ready,
  input  logic        dt_valid,
  input  logic [21:0] dt_addr,
  input  logic [31:0] dt_wdata,
  input  logic [3:0]  dt_wstrb,
  output logic        dt_ready,
  input  logic        mc_valid,
  input  logic [21:0] mc_addr,
  output logic        mc_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        mpu_tbl_dirty,
  output logic [3:0]  mem_wen,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [21:0] MEM_TOP = 22'(MEM_WORDS);
  localparam logic [21:0] TBL_LO  = 22'(MPU_START_ADDR);
  localparam logic [21:0] TBL_HI  = 22'(MPU_START_ADDR + MPU_ITEM_NUM * MPU_ITEM_LEN);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state, state_nx;
  logic [1:0]  gid, win;
  logic        any_req;
  logic [21:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        in_range, is_write, in_tbl;

  assign any_req  = if_valid | dt_valid | mc_valid;
  assign in_range = addr_q < MEM_TOP;
  assign is_write = wstrb_q != 4'b0000;
  assign in_tbl   = (addr_q >= TBL_LO) && (addr_q < TBL_HI);

`ifdef MEM_ARB_RR_EN
  // rr_ptr names the requester that gets first look at the next arbitration
  logic [1:0] rr_ptr;

  always_comb begin
    win = 2'd3;
    case (rr_ptr)
      2'd0:    win = if_valid ? 2'd0 : dt_valid ? 2'd1 : mc_valid ? 2'd2 : 2'd3;
      2'd1:    win = dt_valid ? 2'd1 : mc_valid ? 2'd2 : if_valid ? 2'd0 : 2'd3;
      default: win = mc_valid ? 2'd2 : if_valid ? 2'd0 : dt_valid ? 2'd1 : 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      rr_ptr <= 2'd0;
    else if (state == IDLE && any_req)
      rr_ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
  end
`else
  always_comb begin
    win = mc_valid ? 2'd2 : dt_valid ? 2'd1 : if_valid ? 2'd0 : 2'd3;
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      gid       <= 2'd3;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_rdata <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gid <= win;
        case (win)
          2'd0: begin addr_q <= if_addr; wdata_q <= '0;       wstrb_q <= '0;       end
          2'd1: begin addr_q <= dt_addr; wdata_q <= dt_wdata; wstrb_q <= dt_wstrb; end
          default: begin addr_q <= mc_addr; wdata_q <= '0;    wstrb_q <= '0;       end
        endcase
      end
      if (state == DATA)
        rsp_rdata <= (in_range && !is_write) ? mem_rdata : '0;
    end
  end

  always_comb begin
    state_nx      = state;
    busy          = state != IDLE;
    grant_id      = 2'd3;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wen       = '0;
    if_ready      = 1'b0;
    dt_ready      = 1'b0;
    mc_ready      = 1'b0;
    mpu_tbl_dirty = 1'b0;
    if (state != IDLE) begin
      grant_id  = gid;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    case (state)
      IDLE: if (any_req) state_nx = ADDR;
      ADDR: begin
        state_nx = DATA;
        if (in_range) mem_wen = wstrb_q;
      end
      DATA: state_nx = DONE;
      default: begin
        state_nx      = IDLE;
        if_ready      = gid == 2'd0;
        dt_ready      = gid == 2'd1;
        mc_ready      = gid == 2'd2;
        mpu_tbl_dirty = is_write && in_range && in_tbl;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural synchronous-read memory.
// Priority expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

  localparam int unsigned MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        if_valid = 1'b0, dt_valid = 1'b0, mc_valid = 1'b0;
  logic [21:0] if_addr = '0, dt_addr = '0, mc_addr = '0;
  logic [31:0] dt_wdata = '0;
  logic [3:0]  dt_wstrb = '0;
  logic        if_ready, dt_ready, mc_ready, busy, mpu_tbl_dirty;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [1:0]  grant_id;
  logic [3:0]  mem_wen;
  logic [21:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_WORDS(1024), .MPU_START_ADDR(768), .MPU_ITEM_NUM(16), .MPU_ITEM_LEN(5)
  ) dut (
    .clk(clk), .resetn(resetn),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .dt_valid(dt_valid), .dt_addr(dt_addr), .dt_wdata(dt_wdata), .dt_wstrb(dt_wstrb),
    .dt_ready(dt_ready),
    .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_ready(mc_ready),
    .rsp_rdata(rsp_rdata), .grant_id(grant_id), .busy(busy), .mpu_tbl_dirty(mpu_tbl_dirty),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int unsigned a);
    return (a == 16) ? 32'hDEADBEEF : ((32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  // Memory: out-of-range reads return garbage so the arbiter's zeroing is visible.
  logic [31:0] mem [MEM_WORDS];
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_word(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (32'(mem_addr) < MEM_WORDS) begin
        mem_rdata <= mem[mem_addr[9:0]];
        for (int b = 0; b < 4; b++)
          if (mem_wen[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= 32'hBAD0BAD0;
      end
    end
  end

  typedef struct packed { logic [31:0] rdata; logic dirty; } exp_t;
  exp_t sb_if[$], sb_dt[$], sb_mc[$];
  logic [31:0] model_mem [MEM_WORDS];
  logic [21:0] last_a  [3];
  logic [31:0] last_wd [3];
  logic [3:0]  last_ws [3];
  int total = 0, bad = 0;
  int unsigned repost_n = 0;
  int grant_log[$], ready_cyc[$], addr_cyc[$];
  logic [21:0] addr_log[$];
  int wen_cycles;
  logic [3:0] wen_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic post(input int id, input logic [21:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input bit track);
    exp_t e;
    bit   inr;
    inr     = 32'(a) < MEM_WORDS;
    e.rdata = (inr && ws == 4'b0000) ? model_mem[a[9:0]] : '0;
    e.dirty = inr && ws != 4'b0000 && a >= 22'd768 && a < 22'd848;
    if (inr)
      for (int b = 0; b < 4; b++)
        if (ws[b]) model_mem[a[9:0]][8*b +: 8] = wd[8*b +: 8];
    last_a[id] = a; last_wd[id] = wd; last_ws[id] = ws;
    case (id)
      0: begin if_valid = 1'b1; if_addr = a; if (track) sb_if.push_back(e); end
      1: begin
        dt_valid = 1'b1; dt_addr = a; dt_wdata = wd; dt_wstrb = ws;
        if (track) sb_dt.push_back(e);
      end
      default: begin mc_valid = 1'b1; mc_addr = a; if (track) sb_mc.push_back(e); end
    endcase
  endtask

  function automatic int pending();
    return sb_if.size() + sb_dt.size() + sb_mc.size();
  endfunction

  task automatic retire(input int id);
    exp_t e;
    int   sz;
    sz = (id == 0) ? sb_if.size() : (id == 1) ? sb_dt.size() : sb_mc.size();
    check($sformatf("sb_nonempty_%0d", id), 64'(sz != 0), 64'(1));
    if (sz != 0) begin
      e = (id == 0) ? sb_if.pop_front() : (id == 1) ? sb_dt.pop_front() : sb_mc.pop_front();
      check($sformatf("rdata_%0d", id), 64'(rsp_rdata), 64'(e.rdata));
      check($sformatf("dirty_%0d", id), 64'(mpu_tbl_dirty), 64'(e.dirty));
    end
  endtask

  // Runs cycles until every tracked request has completed, dropping valid after each ready.
  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    bit prev_busy = 1'b0;
    bit d_if, d_dt, d_mc;
    grant_log.delete(); ready_cyc.delete(); addr_cyc.delete(); addr_log.delete();
    wen_cycles = 0; wen_seen = '0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (busy && !prev_busy) begin
        grant_log.push_back(int'(grant_id));
        addr_cyc.push_back(int'(n));
        addr_log.push_back(mem_addr);
      end
      prev_busy = busy;
      if (mem_wen != 4'b0000) begin wen_cycles++; wen_seen = mem_wen; end
      d_if = if_ready; d_dt = dt_ready; d_mc = mc_ready;
      if (d_if || d_dt || d_mc) begin
        check("one_ready", 64'(int'(d_if) + int'(d_dt) + int'(d_mc)), 64'(1));
        ready_cyc.push_back(int'(n));
        if (d_if) retire(0);
        if (d_dt) retire(1);
        if (d_mc) retire(2);
      end else if (mpu_tbl_dirty) begin
        check("stray_dirty", 64'(mpu_tbl_dirty), 64'(0));
      end
      @(posedge clk); #1;
      if (d_if) begin
        if_valid = 1'b0;
        if (repost_n > 0) begin repost_n--; post(0, last_a[0], last_wd[0], last_ws[0], 1'b1); end
      end
      if (d_dt) begin
        dt_valid = 1'b0;
        if (repost_n > 0) begin repost_n--; post(1, last_a[1], last_wd[1], last_ws[1], 1'b1); end
      end
      if (d_mc) mc_valid = 1'b0;
    end
    if (pending() != 0) check("timeout_pending", 64'(pending()), 64'(0));
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    if_valid = 1'b0; dt_valid = 1'b0; mc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    int exp_g[$];
    int nmc;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = init_word(i);
    reset_dut();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(grant_id), 64'(3));
    check("rst_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_readies", 64'({if_ready, dt_ready, mc_ready, mpu_tbl_dirty}), 64'(0));
    check("rst_mem", 64'({mem_wen, mem_addr, mem_wdata}), 64'(0));
    @(posedge clk); #1;

    // single fetch
    post(0, 22'h010, '0, '0, 1'b1);
    drain(20);
    check("fetch_grants", 64'(grant_log.size()), 64'(1));
    if (grant_log.size() == 1 && ready_cyc.size() == 1) begin
      check("fetch_addr", 64'(addr_log[0]), 64'(22'h010));
      check("fetch_gid", 64'(grant_log[0]), 64'(0));
      check("fetch_addr_cyc", 64'(addr_cyc[0]), 64'(2));
      check("fetch_latency", 64'(ready_cyc[0] - addr_cyc[0]), 64'(2));
    end

    // partial write, then read back
    post(1, 22'd5, 32'h12345678, 4'b0011, 1'b1);
    drain(20);
    check("wr_wen_cycles", 64'(wen_cycles), 64'(1));
    check("wr_wen", 64'(wen_seen), 64'(4'b0011));
    if (ready_cyc.size() == 1 && addr_cyc.size() == 1)
      check("wr_latency", 64'(ready_cyc[0] - addr_cyc[0]), 64'(2));
    post(0, 22'd5, '0, '0, 1'b1);
    drain(20);
    check("wr_mem", 64'(mem[5]), 64'(model_mem[5]));

    // out of range and MPU table boundaries
    post(1, 22'd1024, 32'hCAFEF00D, 4'hF, 1'b1);
    drain(20);
    check("oor_wen_cycles", 64'(wen_cycles), 64'(0));
    post(0, 22'd2000, '0, '0, 1'b1);
    drain(20);
    post(1, 22'd771, 32'hA1B2C3D4, 4'hF, 1'b1);
    drain(20);
    post(1, 22'd848, 32'h0F0F0F0F, 4'hF, 1'b1);
    drain(20);
    post(1, 22'd767, 32'h11112222, 4'b1000, 1'b1);
    drain(20);
    post(2, 22'd771, '0, '0, 1'b1);
    drain(20);
    post(1, 22'd847, '0, '0, 1'b1);
    drain(20);

    // three simultaneous requesters
    reset_dut();
    post(0, 22'd32, '0, '0, 1'b1);
    post(1, 22'd40, '0, '0, 1'b1);
    post(2, 22'd800, '0, '0, 1'b1);
`ifdef MEM_ARB_RR_EN
    exp_g = '{0, 1, 2};
`else
    exp_g = '{2, 1, 0};
`endif
    drain(60);
    check("prio_grants", 64'(grant_log.size()), 64'(3));
    if (grant_log.size() == 3 && ready_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("prio_gid%0d", i), 64'(grant_log[i]), 64'(exp_g[i]));
      check("prio_gap01", 64'(ready_cyc[1] - ready_cyc[0]), 64'(4));
      check("prio_gap12", 64'(ready_cyc[2] - ready_cyc[1]), 64'(4));
    end

    // reset during DATA of a refill read
    post(2, 22'd100, '0, '0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    check("abort_in_data", 64'(busy), 64'(1));
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_grant", 64'(grant_id), 64'(3));
    check("abort_ready", 64'(mc_ready), 64'(0));
    check("abort_rdata", 64'(rsp_rdata), 64'(0));
    @(posedge clk); #1;
    mc_valid = 1'b0; resetn = 1'b1;
    nmc = 0;
    repeat (6) begin @(negedge clk); if (mc_ready) nmc++; end
    check("abort_no_ready", 64'(nmc), 64'(0));
    @(posedge clk); #1;

    // dt and if held valid continuously
    reset_dut();
    repost_n = 4;
    post(1, 22'd200, '0, '0, 1'b1);
    post(0, 22'd201, '0, '0, 1'b1);
    drain(100);
`ifdef MEM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1};
`else
    exp_g = '{1, 1, 1, 1, 1, 0};
`endif
    check("held_grants", 64'(grant_log.size()), 64'(6));
    if (grant_log.size() == 6)
      for (int i = 0; i < 6; i++) check($sformatf("held_gid%0d", i), 64'(grant_log[i]), 64'(exp_g[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
